fwd_sel_ctrl: RTL and testbench
===============================

# fwd_sel_ctrl

Pipeline forwarding and load-use stall controller for the Sample MIPS core. It tracks the destination registers of instructions in EX, MEM and WB, and compares them against the source registers of the instruction leaving ID. It produces the registered 2-bit select codes that drive the two 4-input ALU operand muxes, and a one-cycle stall request for load-use hazards.

## Interface
Parameters:
- `REG_AW`, default 5: register address width.
- `SEL_W`, default 2: operand-select width. Fixed by the 4-input operand mux; not overridable in practice.

Ports. One clock; reset is asynchronous and active-low.
- `clk`, input, 1: system clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `id_valid`, input, 1: ID holds a real instruction.
- `id_rs`, `id_rt`, input, REG_AW each: ID source registers.
- `id_use_rs`, `id_use_rt`, input, 1 each: the instruction actually reads that source.
- `id_rd`, input, REG_AW: ID destination register, already muxed from rt/rd.
- `id_reg_write`, input, 1: the ID instruction writes the register file.
- `id_mem_read`, input, 1: the ID instruction is a load.
- `flush`, input, 1: squash the instruction issuing into EX (branch/jump taken).
- `stall`, output, 1: freeze PC and IF/ID. Combinational.
- `fwd_sel_a`, `fwd_sel_b`, output, SEL_W each: operand-A/B select for the instruction now in EX. Registered.

## Operation
Select encoding, applied identically to A and B:
- 00: register-file value.
- 01: EX/MEM ALU result.
- 10: MEM/WB result.
- 11: WB-retired value latch.

Trackers:
- Three stage trackers (EX, MEM, WB), each holding {valid, rd, reg_write, mem_read}.
- Every cycle the contents shift EX→MEM→WB unconditionally; the back end never stalls.
- Issue condition: `id_valid && !stall && !flush`.
- On issue, EX loads the ID fields. Otherwise EX loads a bubble (valid=0) and both sels register as 00.

Hazard match:
- A match against stage S requires S.valid, S.reg_write, S.rd == source, and source != 0.
- Matches apply only to sources whose use flag is set.

Select computation, evaluated at issue and registered into `fwd_sel_*`:
- Match in current EX → 01 (that instruction will sit in EX/MEM).
- Else match in current MEM → 10.
- Else match in current WB → 11.
- Else → 00.
- Priority is EX > MEM > WB, so the youngest producer wins.

Load-use stall:
- `stall = id_valid && EX.valid && EX.mem_read && EX.reg_write && EX.rd != 0 && ((id_use_rs && id_rs == EX.rd) || (id_use_rt && id_rt == EX.rd))`.
- The stall lasts exactly one cycle: the load moves to MEM, a bubble enters EX, and on the following cycle the same ID instruction issues with select 10.
- `flush` takes precedence over stall for the EX load: EX gets a bubble. `stall` itself is still driven by the formula above.

## Timing
- Reset (async assert, sync release with `clk`): all tracker valid bits = 0, rd = 0; `fwd_sel_a` = `fwd_sel_b` = 00. `stall` evaluates to 0 because EX is invalid.
- Select latency: 1 cycle. The sel computed in cycle N for the issuing instruction is stable throughout cycle N+1, while that instruction is in EX.
- `stall` has zero latency and depends only on ID inputs plus the registered EX tracker; there is no combinational path from `fwd_sel_*`.
- Reset asserted mid-operation clears all trackers immediately. The first post-reset issue sees no hazards.
- Same rd in two stages: the younger stage wins per priority.
- rd = 0 never forwards and never stalls.
- Simultaneous flush and valid ID: EX gets a bubble; sels are 00 next cycle.

## Structure
- Package `mips_fwd_pkg` holds:
  - localparams `FWD_RF` = 2'b00, `FWD_EXMEM` = 2'b01, `FWD_MEMWB` = 2'b10, `FWD_WBRET` = 2'b11;
  - the tracker record type {valid, rd, reg_write, mem_read}.
- Sub-module `fwd_stage_reg`: one tracker register with async active-low reset and a bubble-insert input, instantiated three times.
- The priority compare is written once as a function and applied to both A and B.

## Test plan
- Dependent ALU ops back-to-back (`add $3,$1,$2`; `sub $4,$3,$5`) → sub in EX with `fwd_sel_a` = 01, `fwd_sel_b` = 00, `stall` = 0.
- Producer at distance 2 → 10. Distance 3 → 11. Distance 4 → 00.
- Load-use (`lw $8,0($9)`; `add $10,$8,$8`) → `stall` = 1 for exactly one cycle, bubble in EX, then add in EX with both sels = 10.
- Writes to $0 followed by a reader of $0 → sels 00, `stall` = 0, including the load-to-$0 case.
- Two producers of $7 at distances 1 and 2 → select 01 (youngest wins). `flush` on issue → next-cycle sels 00 and the EX tracker invalid.
- `rst_n` pulsed low mid-sequence with a load in EX → `stall` drops to 0 asynchronously and sels read 00. The first post-reset dependent pair forwards correctly with 01.

Source files
------------

// File: rtl/mips_fwd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : mips_fwd_pkg                                                    |
// | Purpose  : Shared definitions for the forwarding / load-use controller:    |
// |            operand-select codes, the per-stage tracker record and the      |
// |            priority compare used for both ALU operands.                    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package mips_fwd_pkg;

  // Operand-mux select codes
  localparam logic [1:0] FWD_RF    = 2'b00;  // register-file value
  localparam logic [1:0] FWD_EXMEM = 2'b01;  // EX/MEM ALU result
  localparam logic [1:0] FWD_MEMWB = 2'b10;  // MEM/WB result
  localparam logic [1:0] FWD_WBRET = 2'b11;  // WB-retired value latch

  // Register-address width carried inside a tracker record
  localparam int unsigned TRK_RD_W = 5;

  // One pipeline-stage tracker
  typedef struct packed {
    logic                valid;
    logic [TRK_RD_W-1:0] rd;
    logic                reg_write;
    logic                mem_read;
  } trk_t;

  // A stage can supply a source only if it holds a real register-writing
  // instruction targeting that source; $0 is hard-wired and never forwards.
  function automatic logic trk_match(input trk_t s, input logic [TRK_RD_W-1:0] src);
    return s.valid && s.reg_write && (s.rd == src) && (src != '0);
  endfunction

  // Youngest producer wins: EX, then MEM, then WB.
  function automatic logic [1:0] fwd_select(input trk_t ex,
                                            input trk_t mem,
                                            input trk_t wb,
                                            input logic [TRK_RD_W-1:0] src,
                                            input logic use_src);
    logic [1:0] sel;
    sel = FWD_RF;
    if (use_src) begin
      if (trk_match(ex, src))       sel = FWD_EXMEM;
      else if (trk_match(mem, src)) sel = FWD_MEMWB;
      else if (trk_match(wb, src))  sel = FWD_WBRET;
    end
    return sel;
  endfunction

endpackage : mips_fwd_pkg
`default_nettype wire

// File: rtl/fwd_stage_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fwd_stage_reg                                                   |
// | Purpose  : One pipeline-stage tracker register. Loads d_i every cycle, or  |
// |            an all-zero bubble when bubble_i is high.                       |
// | Ports    : clk      - clock                                                |
// |            rst_n    - asynchronous active-low reset                        |
// |            d_i      - tracker record to load                               |
// |            bubble_i - load an invalid (all-zero) record instead of d_i     |
// |            q_o      - registered tracker record                            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module fwd_stage_reg
  import mips_fwd_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  trk_t d_i,
  input  logic bubble_i,
  output trk_t q_o
);

  trk_t trk_q;
  trk_t trk_d;

  always_comb begin
    trk_d = d_i;
    if (bubble_i) begin
      trk_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trk_q <= '0;
    end else begin
      trk_q <= trk_d;
    end
  end

  assign q_o = trk_q;

endmodule : fwd_stage_reg
`default_nettype wire

// File: rtl/fwd_sel_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fwd_sel_ctrl                                                    |
// | Purpose  : Forwarding-select and load-use stall controller. Tracks the     |
// |            destinations of the EX, MEM and WB instructions and compares    |
// |            them with the sources of the instruction leaving ID.            |
// | Ports    : clk, rst_n            - clock, async active-low reset           |
// |            id_valid              - ID holds a real instruction             |
// |            id_rs, id_rt          - ID source registers                     |
// |            id_use_rs, id_use_rt  - source actually read                    |
// |            id_rd                 - ID destination register                 |
// |            id_reg_write          - ID instruction writes the RF            |
// |            id_mem_read           - ID instruction is a load                |
// |            flush                 - squash the instruction issuing to EX    |
// |            stall                 - freeze PC and IF/ID (combinational)     |
// |            fwd_sel_a, fwd_sel_b  - operand selects for EX (registered)     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module fwd_sel_ctrl
  import mips_fwd_pkg::*;
#(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned SEL_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              flush,
  output logic              stall,
  output logic [SEL_W-1:0]  fwd_sel_a,
  output logic [SEL_W-1:0]  fwd_sel_b
);

  // The tracker record and the select codes have fixed widths.
  if (REG_AW != TRK_RD_W) begin : g_aw_check
    $error("fwd_sel_ctrl: REG_AW must equal mips_fwd_pkg::TRK_RD_W");
  end
  if (SEL_W != 2) begin : g_sel_check
    $error("fwd_sel_ctrl: SEL_W must be 2 for the 4-input operand mux");
  end

  logic [TRK_RD_W-1:0] w_rs;
  logic [TRK_RD_W-1:0] w_rt;
  trk_t                w_id_trk;
  trk_t                w_ex_trk;
  trk_t                w_mem_trk;
  trk_t                w_wb_trk;
  logic                w_issue;
  logic                w_rs_lu;
  logic                w_rt_lu;

  logic [SEL_W-1:0]    sel_a_q, sel_a_d;
  logic [SEL_W-1:0]    sel_b_q, sel_b_d;

  assign w_rs = TRK_RD_W'(id_rs);
  assign w_rt = TRK_RD_W'(id_rt);

  always_comb begin
    w_id_trk           = '0;
    w_id_trk.valid     = 1'b1;
    w_id_trk.rd        = TRK_RD_W'(id_rd);
    w_id_trk.reg_write = id_reg_write;
    w_id_trk.mem_read  = id_mem_read;
  end

  // Load-use: the loaded value is not available until the load reaches MEM,
  // so a dependent ID instruction waits one cycle. Only the registered EX
  // tracker and ID inputs feed this path.
  assign w_rs_lu = id_use_rs && (w_rs == w_ex_trk.rd);
  assign w_rt_lu = id_use_rt && (w_rt == w_ex_trk.rd);
  assign stall   = id_valid && w_ex_trk.valid && w_ex_trk.mem_read &&
                   w_ex_trk.reg_write && (w_ex_trk.rd != '0) &&
                   (w_rs_lu || w_rt_lu);

  // Flush outranks stall for what enters EX; stall itself is unaffected.
  assign w_issue = id_valid && !stall && !flush;

  // Back end never stalls: EX always advances to MEM and MEM to WB.
  fwd_stage_reg u_ex_trk (
    .clk      (clk),
    .rst_n    (rst_n),
    .d_i      (w_id_trk),
    .bubble_i (!w_issue),
    .q_o      (w_ex_trk)
  );

  fwd_stage_reg u_mem_trk (
    .clk      (clk),
    .rst_n    (rst_n),
    .d_i      (w_ex_trk),
    .bubble_i (1'b0),
    .q_o      (w_mem_trk)
  );

  fwd_stage_reg u_wb_trk (
    .clk      (clk),
    .rst_n    (rst_n),
    .d_i      (w_mem_trk),
    .bubble_i (1'b0),
    .q_o      (w_wb_trk)
  );

  // Selects are computed against the trackers as they stand now; one edge
  // later every producer has moved down a stage, which is exactly what the
  // select codes name (EX -> EX/MEM, MEM -> MEM/WB, WB -> retired latch).
  always_comb begin
    sel_a_d = SEL_W'(FWD_RF);
    sel_b_d = SEL_W'(FWD_RF);
    if (w_issue) begin
      sel_a_d = SEL_W'(fwd_select(w_ex_trk, w_mem_trk, w_wb_trk, w_rs, id_use_rs));
      sel_b_d = SEL_W'(fwd_select(w_ex_trk, w_mem_trk, w_wb_trk, w_rt, id_use_rt));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_a_q <= SEL_W'(FWD_RF);
      sel_b_q <= SEL_W'(FWD_RF);
    end else begin
      sel_a_q <= sel_a_d;
      sel_b_q <= sel_b_d;
    end
  end

  assign fwd_sel_a = sel_a_q;
  assign fwd_sel_b = sel_b_q;

endmodule : fwd_sel_ctrl
`default_nettype wire

// File: tb/tb_fwd_sel_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_fwd_sel_ctrl                                                 |
// | Purpose  : Self-checking bench for fwd_sel_ctrl. Each ID-stage step pushes |
// |            its expected operand selects into a scoreboard queue; they are  |
// |            popped and compared once the instruction sits in EX.            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_fwd_sel_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_use_rs;
  logic       id_use_rt;
  logic [4:0] id_rd;
  logic       id_reg_write;
  logic       id_mem_read;
  logic       flush;
  logic       stall;
  logic [1:0] fwd_sel_a;
  logic [1:0] fwd_sel_b;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [3:0] exp_q[$];

  fwd_sel_ctrl #(.REG_AW(5), .SEL_W(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_use_rs    (id_use_rs),
    .id_use_rt    (id_use_rt),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .flush        (flush),
    .stall        (stall),
    .fwd_sel_a    (fwd_sel_a),
    .fwd_sel_b    (fwd_sel_b)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One ID-stage cycle: drive, check stall now, check selects after the edge.
  task automatic step(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                      input logic urs, input logic urt, input logic [4:0] rd,
                      input logic rw, input logic mr, input logic fl,
                      input logic exp_stall, input logic [1:0] ea,
                      input logic [1:0] eb, input string name);
    logic [3:0] e;
    id_valid     = v;
    id_rs        = rs;
    id_rt        = rt;
    id_use_rs    = urs;
    id_use_rt    = urt;
    id_rd        = rd;
    id_reg_write = rw;
    id_mem_read  = mr;
    flush        = fl;
    #1;
    n_cmp++;
    if (stall !== exp_stall) begin
      n_fail++;
      $display("FAIL %s stall: got %b expected %b", name, stall, exp_stall);
    end
    exp_q.push_back({ea, eb});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    n_cmp++;
    if ({fwd_sel_a, fwd_sel_b} !== e) begin
      n_fail++;
      $display("FAIL %s sels: got a=%b b=%b expected a=%b b=%b",
               name, fwd_sel_a, fwd_sel_b, e[3:2], e[1:0]);
    end
  endtask

  task automatic bubbles(input int n);
    for (int i = 0; i < n; i++)
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, "bubble");
  endtask

  task automatic set_idle();
    id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
    id_rd = 0; id_reg_write = 0; id_mem_read = 0; flush = 0;
  endtask

  task automatic test_reset();
    set_idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    // Would-be load-use consumer in ID: EX is empty, so no stall.
    id_valid = 1; id_rs = 5'd8; id_use_rs = 1;
    #1;
    n_cmp++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_stall: got %b expected 0", stall);
    end
    n_cmp++;
    if ({fwd_sel_a, fwd_sel_b} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_sels: got a=%b b=%b expected 00 00", fwd_sel_a, fwd_sel_b);
    end
    set_idle();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    bubbles(3);
    step(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 2'b00, 2'b00, "add_3_1_2");
    step(1, 3, 5, 1, 1, 4, 1, 0, 0, 0, 2'b01, 2'b00, "sub_4_3_5");
  endtask

  task automatic test_distance();
    logic [1:0] exp_tab [4];
    exp_tab[0] = 2'b01; exp_tab[1] = 2'b10; exp_tab[2] = 2'b11; exp_tab[3] = 2'b00;
    for (int d = 1; d <= 4; d++) begin
      bubbles(3);
      step(1, 1, 2, 1, 1, 6, 1, 0, 0, 0, 2'b00, 2'b00, "dist_producer");
      bubbles(d - 1);
      // rs is $0 (never forwards), rt carries the dependency
      step(1, 0, 6, 1, 1, 9, 1, 0, 0, 0, 2'b00, exp_tab[d-1], $sformatf("dist_%0d", d));
    end
  endtask

  task automatic test_load_use();
    bubbles(3);
    step(1, 9, 0, 1, 0, 8, 1, 1, 0, 0, 2'b00, 2'b00, "lw_8");
    step(1, 8, 8, 1, 1, 10, 1, 0, 0, 1, 2'b00, 2'b00, "lu_stall");
    step(1, 8, 8, 1, 1, 10, 1, 0, 0, 0, 2'b10, 2'b10, "lu_issue");
    // dependency via rt only
    bubbles(3);
    step(1, 9, 0, 1, 0, 8, 1, 1, 0, 0, 2'b00, 2'b00, "lw_8_rt");
    step(1, 1, 8, 1, 1, 10, 1, 0, 0, 1, 2'b00, 2'b00, "lu_rt_stall");
    step(1, 1, 8, 1, 1, 10, 1, 0, 0, 0, 2'b00, 2'b10, "lu_rt_issue");
    // register named but not read: no stall
    bubbles(3);
    step(1, 9, 0, 1, 0, 8, 1, 1, 0, 0, 2'b00, 2'b00, "lw_8_nouse");
    step(1, 8, 8, 0, 0, 10, 1, 0, 0, 0, 2'b00, 2'b00, "lu_nouse");
  endtask

  task automatic test_zero_reg();
    bubbles(3);
    step(1, 1, 2, 1, 1, 0, 1, 0, 0, 0, 2'b00, 2'b00, "alu_w0");
    step(1, 0, 0, 1, 1, 4, 1, 0, 0, 0, 2'b00, 2'b00, "r0_after_alu");
    bubbles(3);
    step(1, 9, 0, 1, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, "lw_w0");
    step(1, 0, 0, 1, 1, 4, 1, 0, 0, 0, 2'b00, 2'b00, "r0_after_lw");
  endtask

  task automatic test_priority();
    bubbles(3);
    step(1, 1, 2, 1, 1, 7, 1, 0, 0, 0, 2'b00, 2'b00, "p7_old");
    step(1, 1, 2, 1, 1, 7, 1, 0, 0, 0, 2'b00, 2'b00, "p7_young");
    step(1, 7, 7, 1, 1, 11, 1, 0, 0, 0, 2'b01, 2'b01, "prio_ex_mem");
    bubbles(3);
    step(1, 1, 2, 1, 1, 7, 1, 0, 0, 0, 2'b00, 2'b00, "p7_old2");
    step(1, 1, 2, 1, 1, 7, 1, 0, 0, 0, 2'b00, 2'b00, "p7_young2");
    bubbles(1);
    step(1, 7, 0, 1, 0, 11, 1, 0, 0, 0, 2'b10, 2'b00, "prio_mem_wb");
  endtask

  task automatic test_flush();
    bubbles(3);
    step(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 2'b00, 2'b00, "fl_producer");
    step(1, 3, 0, 1, 0, 7, 1, 0, 1, 0, 2'b00, 2'b00, "fl_squashed");
    n_cmp++;
    if (dut.w_ex_trk.valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_ex_valid: got %b expected 0", dut.w_ex_trk.valid);
    end
    step(1, 7, 3, 1, 1, 12, 1, 0, 0, 0, 2'b00, 2'b10, "fl_after");
    // flush with a load-use hazard in ID: stall still asserted
    bubbles(3);
    step(1, 9, 0, 1, 0, 8, 1, 1, 0, 0, 2'b00, 2'b00, "fl_lw_8");
    step(1, 8, 0, 1, 0, 10, 1, 0, 1, 1, 2'b00, 2'b00, "fl_over_stall");
    step(1, 8, 0, 1, 0, 10, 1, 0, 0, 0, 2'b10, 2'b00, "fl_reissue");
  endtask

  task automatic test_reset_mid();
    bubbles(3);
    step(1, 1, 5, 1, 1, 2, 1, 0, 0, 0, 2'b00, 2'b00, "rm_producer");
    step(1, 2, 0, 1, 0, 8, 1, 1, 0, 0, 2'b01, 2'b00, "rm_lw_8");
    id_valid = 1; id_rs = 8; id_rt = 8; id_use_rs = 1; id_use_rt = 1;
    id_rd = 10; id_reg_write = 1; id_mem_read = 0; flush = 0;
    #1;
    n_cmp++;
    if (stall !== 1'b1) begin
      n_fail++;
      $display("FAIL rm_pre_stall: got %b expected 1", stall);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL rm_async_stall: got %b expected 0", stall);
    end
    n_cmp++;
    if ({fwd_sel_a, fwd_sel_b} !== 4'b0000) begin
      n_fail++;
      $display("FAIL rm_async_sels: got a=%b b=%b expected 00 00", fwd_sel_a, fwd_sel_b);
    end
    set_idle();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // $8 was the load in EX before reset: no hazard remains
    step(1, 8, 2, 1, 1, 3, 1, 0, 0, 0, 2'b00, 2'b00, "rm_first");
    step(1, 3, 5, 1, 1, 4, 1, 0, 0, 0, 2'b01, 2'b00, "rm_dependent");
  endtask

  initial begin
    rst_n = 1'b0;
    set_idle();
    test_reset();
    test_back_to_back();
    test_distance();
    test_load_use();
    test_zero_reg();
    test_priority();
    test_flush();
    test_reset_mid();
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_fwd_sel_ctrl
`default_nettype wire
